// File: rtl/databus_axi_wr.sv
// databus_axi_wr: turns one versat databus write transfer into a single AXI4
// INCR write burst. The final databus word is acknowledged only once the AXI
// write response has returned, so upstream "done" means the data is committed.
module databus_axi_wr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  databus_valid,
  output logic                  databus_ready,
  input  logic [ADDR_W-1:0]     databus_addr,
  input  logic [DATA_W-1:0]     databus_wdata,
  input  logic [DATA_W/8-1:0]   databus_wstrb,
  input  logic [7:0]            databus_len,
  output logic [DATA_W-1:0]     databus_rdata,
  output logic                  databus_last,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  busy,
  output logic                  error
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [2:0] AW_SIZE = 3'($clog2(STRB_W));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                awvalid_q, awvalid_d;
  logic                error_q, error_d;

  logic in_data;
  logic in_resp;
  logic final_beat;

  assign in_data    = (state_q == DATA);
  assign in_resp    = (state_q == RESP);
  // Counter is compared against the captured length only, so 256 beats never wrap.
  assign final_beat = (beat_cnt_q == len_q);

  // Next-state and registered-output computation for the burst sequencer.
  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    awvalid_d  = awvalid_q;
    error_d    = error_q;
    case (state_q)
      IDLE: begin
        if (databus_valid) begin
          awaddr_d   = databus_addr;
          len_d      = databus_len;
          beat_cnt_d = 8'd0;
          error_d    = 1'b0;
          awvalid_d  = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (databus_valid && m_axi_wready) begin
          if (final_beat) begin
            state_d = RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      RESP: begin
        if (m_axi_bvalid) begin
          error_d = (m_axi_bresp != 2'b00);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight AXI transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      awaddr_q   <= '0;
      len_q      <= 8'd0;
      beat_cnt_q <= 8'd0;
      awvalid_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      awvalid_q  <= awvalid_d;
      error_q    <= error_d;
    end
  end

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AW_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;

  // W channel is a zero-latency pass-through, gated to the DATA phase.
  assign m_axi_wdata  = databus_wdata;
  assign m_axi_wstrb  = databus_wstrb;
  assign m_axi_wvalid = in_data & databus_valid;
  assign m_axi_wlast  = in_data & final_beat;

  assign m_axi_bready = in_resp;

  // Final word is held upstream until the write response confirms it.
  assign databus_ready = (in_data & ~final_beat & m_axi_wready) | (in_resp & m_axi_bvalid);
  assign databus_last  = in_resp & m_axi_bvalid;
  assign databus_rdata = '0;

  assign busy  = (state_q != IDLE);
  assign error = error_q;

endmodule

// File: tb/tb_databus_axi_wr.sv
// Bench for databus_axi_wr: cycle-stepped upstream writer and AXI slave with a
// transaction-level model of what each burst must look like.
module tb_databus_axi_wr;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic          clk, rst;
  logic          databus_valid, databus_ready, databus_last;
  logic [AW-1:0] databus_addr;
  logic [DW-1:0] databus_wdata, databus_rdata;
  logic [SW-1:0] databus_wstrb;
  logic [7:0]    databus_len;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          busy, error;

  databus_axi_wr #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .databus_valid(databus_valid), .databus_ready(databus_ready),
    .databus_addr(databus_addr), .databus_wdata(databus_wdata),
    .databus_wstrb(databus_wstrb), .databus_len(databus_len),
    .databus_rdata(databus_rdata), .databus_last(databus_last),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] words [256];
  logic [SW-1:0] strbs [256];

  // Runs one transfer, stepping one cycle per iteration (drive at negedge,
  // sample 1ns later, handshakes take effect at the following posedge).
  task automatic run_xfer(input logic [AW-1:0] addr, input int len, input int awdelay,
                          input bit rand_wready, input bit gaps, input logic [1:0] resp,
                          input int abort_at, input bit fixed_data);
    int idx = 0, beat = 0, aw_cycles = 0, cyc = 0;
    bit up_valid = 0, aw_done = 0, started = 0, resp_pend = 0, resp_next = 0, done = 0;
    bit exp_ack;
    for (int i = 0; i <= len; i++) begin
      words[i] = fixed_data ? DW'(32'hA0 + i) : DW'($urandom);
      strbs[i] = fixed_data ? {SW{1'b1}} : SW'($urandom);
    end
    databus_addr = addr;
    databus_len  = 8'(len);
    while (!done && cyc < 3000) begin
      if (!up_valid) up_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      databus_valid = up_valid;
      databus_wdata = words[idx];
      databus_wstrb = strbs[idx];
      m_axi_awready = (aw_cycles >= awdelay);
      m_axi_wready  = rand_wready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_bvalid  = resp_pend;
      m_axi_bresp   = resp_pend ? resp : 2'b00;
      #1;
      check_eq("awvalid", m_axi_awvalid, started && !aw_done);
      if (m_axi_awvalid) begin
        check_eq("awaddr", m_axi_awaddr, addr);
        check_eq("awlen", m_axi_awlen, len);
        check_eq("awsize", m_axi_awsize, 3'd2);
        check_eq("awburst", m_axi_awburst, 2'b01);
        check_eq("err_clr", error, 1'b0);
        aw_cycles++;
      end
      check_eq("wvalid", m_axi_wvalid, aw_done && databus_valid && (beat <= len));
      exp_ack = (databus_valid && aw_done && (idx < len) && m_axi_wready) || resp_pend;
      check_eq("ack", databus_ready && databus_valid, exp_ack);
      check_eq("last", databus_last, resp_pend);
      check_eq("busy", busy, started);
      if (resp_pend) check_eq("bready", m_axi_bready, 1'b1);
      resp_next = 0;
      if (m_axi_awvalid && m_axi_awready) aw_done = 1;
      if (m_axi_wvalid && m_axi_wready) begin
        check_eq("wdata", m_axi_wdata, words[beat]);
        check_eq("wstrb", m_axi_wstrb, strbs[beat]);
        check_eq("wlast", m_axi_wlast, beat == len);
        if (beat == len) resp_next = 1;
        beat++;
      end
      if (resp_pend) done = 1;
      if (databus_valid) started = 1;
      if (databus_valid && databus_ready) begin
        if (idx < len) idx++;
        up_valid = 0;
      end
      resp_pend = resp_next;
      cyc++;
      if (abort_at >= 0 && beat == abort_at) begin
        rst = 1'b1;
        #1;
        check_eq("rst_ready", databus_ready, 1'b0);
        check_eq("rst_last", databus_last, 1'b0);
        check_eq("rst_awvalid", m_axi_awvalid, 1'b0);
        check_eq("rst_wvalid", m_axi_wvalid, 1'b0);
        check_eq("rst_wlast", m_axi_wlast, 1'b0);
        check_eq("rst_bready", m_axi_bready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_error", error, 1'b0);
        check_eq("rst_awaddr", m_axi_awaddr, 0);
        check_eq("rst_awlen", m_axi_awlen, 0);
        @(negedge clk);
        databus_valid = 1'b0;
        m_axi_bvalid  = 1'b0;
        rst = 1'b0;
        $display("xfer addr=%0h len=%0d aborted after %0d beats", addr, len, beat);
        return;
      end
      @(negedge clk);
    end
    if (!done) check_eq("timeout", 1'b0, 1'b1);
    check_eq("beats", beat, len + 1);
    databus_valid = 1'b0;
    m_axi_bvalid  = 1'b0;
    #1;
    check_eq("error", error, resp != 2'b00);
    check_eq("idle", busy, 1'b0);
    check_eq("rdata", databus_rdata, 0);
    $display("xfer addr=%0h len=%0d resp=%0d cycles=%0d", addr, len, resp, cyc);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    databus_valid = 0; databus_addr = 0; databus_wdata = 0; databus_wstrb = 0; databus_len = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_ready", databus_ready, 1'b0);
    check_eq("reset_awvalid", m_axi_awvalid, 1'b0);
    check_eq("reset_wlast", m_axi_wlast, 1'b0);
    check_eq("reset_bready", m_axi_bready, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_error", error, 1'b0);
    check_eq("reset_awaddr", m_axi_awaddr, 0);
    check_eq("reset_awsize", m_axi_awsize, 3'd2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_xfer(32'h1000, 3, 0, 0, 0, 2'b00, -1, 1);
    run_xfer(32'h2000, 0, 3, 0, 0, 2'b00, -1, 0);
    run_xfer(32'h3000, 7, 0, 1, 1, 2'b00, -1, 0);
    run_xfer(32'h4000, 2, 1, 0, 0, 2'b10, -1, 0);
    run_xfer(32'h5000, 1, 0, 0, 0, 2'b00, -1, 0);
    run_xfer(32'h6000, 255, 2, 1, 0, 2'b00, -1, 0);
    run_xfer(32'h7000, 3, 0, 0, 0, 2'b00, 2, 0);
    run_xfer(32'h8000, 3, 0, 0, 0, 2'b00, -1, 0);
    for (int t = 0; t < 8; t++) begin
      run_xfer(AW'($urandom) & 32'hFFFF_F000, $urandom_range(0, 15), $urandom_range(0, 3),
               1, 1, 2'($urandom_range(0, 3)), -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
